// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: operand forwarding selects, load-use stall, branch flush, MDU sequencing FSM.
// Latency: forwarding, stall and flush are combinational (zero cycles); MDU result valid MUL/DIV_CYCLES+1 cycles after start.
// Backpressure: Stall holds PC and IF/ID and bubbles ID/EX on load-use or MDU-busy conflicts; Flush (branch) overrides Stall.
//
// Ports:
//   i_clk, i_clrn                  clock, synchronous active-low reset (all outputs forced 0 while low)
//   i_d_rs/rt, i_d_use_rs/rt       decode source registers and whether they are really read
//   i_d_md_start/op/read           decode mult/div start, op (0 mul, 1 div), HI/LO read
//   i_e_rd/wreg/mem2reg            EX destination, write enable, load flag
//   i_m_rd/wreg/mem2reg            MEM destination, write enable, load flag
//   i_e_branch_taken               branch resolved taken in EX
//   o_fwd_sel_a/b                  00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
//   o_stall, o_flush               pipeline hold / squash
//   o_md_busy, o_md_done, o_md_count   MDU executing, one-cycle done pulse, remaining cycles - 1
//
// Build option: MDU_DIV_EN. When defined, divides run through a DIV state for DIV_CYCLES.
// When undefined, a divide start goes straight to DONE (the datapath writes 0 to HI/LO).

module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             i_clk,
    input  logic             i_clrn,
    input  logic [4:0]       i_d_rs,
    input  logic [4:0]       i_d_rt,
    input  logic             i_d_use_rs,
    input  logic             i_d_use_rt,
    input  logic             i_d_md_start,
    input  logic             i_d_md_op,
    input  logic             i_d_md_read,
    input  logic [4:0]       i_e_rd,
    input  logic [4:0]       i_m_rd,
    input  logic             i_e_wreg,
    input  logic             i_m_wreg,
    input  logic             i_e_mem2reg,
    input  logic             i_m_mem2reg,
    input  logic             i_e_branch_taken,
    output logic [1:0]       o_fwd_sel_a,
    output logic [1:0]       o_fwd_sel_b,
    output logic             o_stall,
    output logic             o_flush,
    output logic             o_md_busy,
    output logic             o_md_done,
    output logic [CNT_W-1:0] o_md_count
);

    // Counter must be able to hold the longest load value (cycles - 1).
    generate
        if ((MUL_CYCLES < 1) || (DIV_CYCLES < 1) ||
            ((MUL_CYCLES - 1) >= (1 << CNT_W)) || ((DIV_CYCLES - 1) >= (1 << CNT_W))) begin : g_bad_params
            $error("pipe_hazard_ctrl: MUL_CYCLES/DIV_CYCLES must be >= 1 and fit CNT_W");
        end
    endgenerate

    // FSM encoding. 2'd2 is left unused when the divider is not built.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef MDU_DIV_EN
    localparam logic [1:0] ST_DIV  = 2'd2;
`endif
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
`ifdef MDU_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // ------------------------------------------------------------------
    // Register match detection. r0 is hard-wired zero, so a write to it
    // never creates a dependency.
    // ------------------------------------------------------------------
    logic w_e_hit_rs, w_e_hit_rt, w_m_hit_rs, w_m_hit_rt;

    assign w_e_hit_rs = i_d_use_rs && (i_e_rd == i_d_rs) && (i_e_rd != 5'd0);
    assign w_e_hit_rt = i_d_use_rt && (i_e_rd == i_d_rt) && (i_e_rd != 5'd0);
    assign w_m_hit_rs = i_d_use_rs && (i_m_rd == i_d_rs) && (i_m_rd != 5'd0);
    assign w_m_hit_rt = i_d_use_rt && (i_m_rd == i_d_rt) && (i_m_rd != 5'd0);

    // Youngest producer wins. An EX-stage load cannot forward (its data
    // does not exist yet); that case falls through and is covered by the
    // load-use stall instead.
    function automatic logic [1:0] fwd_sel(input logic e_hit, input logic m_hit);
        logic [1:0] sel;
        sel = 2'b00;
        if (e_hit && i_e_wreg && !i_e_mem2reg) begin
            sel = 2'b01;
        end else if (m_hit && i_m_wreg && i_m_mem2reg) begin
            sel = 2'b11;
        end else if (m_hit && i_m_wreg) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_fwd_a = fwd_sel(w_e_hit_rs, w_m_hit_rs);
    assign w_fwd_b = fwd_sel(w_e_hit_rt, w_m_hit_rt);

    // ------------------------------------------------------------------
    // Stall sources
    // ------------------------------------------------------------------
    logic w_load_stall, w_md_stall, w_state_busy, w_md_accept;

    // r0 is already excluded by the hit terms.
    assign w_load_stall = i_e_wreg && i_e_mem2reg && (w_e_hit_rs || w_e_hit_rt);

`ifdef MDU_DIV_EN
    assign w_state_busy = (r_state == ST_MUL) || (r_state == ST_DIV);
`else
    assign w_state_busy = (r_state == ST_MUL);
`endif

    // HI/LO readers and new starts must wait while the unit is running;
    // in DONE the result is already valid so both may proceed.
    assign w_md_stall = (i_d_md_start || i_d_md_read) && w_state_busy;

    // A start squashed by a taken branch, or held by any stall, must not
    // launch the unit: it will be re-presented when decode advances.
    assign w_md_accept = i_d_md_start && !w_load_stall && !w_md_stall && !i_e_branch_taken;

    // ------------------------------------------------------------------
    // MDU sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        if (w_state_busy) begin
            // MUL or DIV: count down to zero, then present the result.
            if (r_cnt == CNT_ZERO) begin
                w_state_nxt = ST_DONE;
                w_cnt_nxt   = CNT_ZERO;
            end else begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt - CNT_ONE;
            end
        end else if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
            if (w_md_accept) begin
                if (!i_d_md_op) begin
                    w_state_nxt = ST_MUL;
                    w_cnt_nxt   = MUL_LOAD;
                end else begin
`ifdef MDU_DIV_EN
                    w_state_nxt = ST_DIV;
                    w_cnt_nxt   = DIV_LOAD;
`else
                    // No divider: complete immediately, HI/LO written as 0.
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = CNT_ZERO;
`endif
                end
            end
        end
        // Any unused encoding falls back to IDLE via the defaults.
    end

    // Reset aborts any operation in flight.
    always_ff @(posedge i_clk) begin
        if (!i_clrn) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything is held at zero while reset is asserted, so the
    // pipeline sees no stall/flush/forwarding during reset.
    // ------------------------------------------------------------------
    assign o_fwd_sel_a = i_clrn ? w_fwd_a : 2'b00;
    assign o_fwd_sel_b = i_clrn ? w_fwd_b : 2'b00;
    assign o_flush     = i_clrn && i_e_branch_taken;
    assign o_stall     = i_clrn && (w_load_stall || w_md_stall) && !i_e_branch_taken;
    assign o_md_busy   = i_clrn && w_state_busy;
    assign o_md_done   = i_clrn && (r_state == ST_DONE);
    assign o_md_count  = (i_clrn && w_state_busy) ? r_cnt : CNT_ZERO;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: scoreboard of expected outputs per cycle.
// Latency: expectations are compared at the falling edge of the cycle they were driven in.
// Backpressure: none; stimulus is a fixed cycle-by-cycle script.

module tb_pipe_hazard_ctrl;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = 6;

    logic             clk;
    logic             i_clrn;
    logic [4:0]       i_d_rs, i_d_rt, i_e_rd, i_m_rd;
    logic             i_d_use_rs, i_d_use_rt;
    logic             i_d_md_start, i_d_md_op, i_d_md_read;
    logic             i_e_wreg, i_m_wreg, i_e_mem2reg, i_m_mem2reg;
    logic             i_e_branch_taken;
    logic [1:0]       o_fwd_sel_a, o_fwd_sel_b;
    logic             o_stall, o_flush, o_md_busy, o_md_done;
    logic [CNT_W-1:0] o_md_count;

    pipe_hazard_ctrl #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_clrn          (i_clrn),
        .i_d_rs          (i_d_rs),
        .i_d_rt          (i_d_rt),
        .i_d_use_rs      (i_d_use_rs),
        .i_d_use_rt      (i_d_use_rt),
        .i_d_md_start    (i_d_md_start),
        .i_d_md_op       (i_d_md_op),
        .i_d_md_read     (i_d_md_read),
        .i_e_rd          (i_e_rd),
        .i_m_rd          (i_m_rd),
        .i_e_wreg        (i_e_wreg),
        .i_m_wreg        (i_m_wreg),
        .i_e_mem2reg     (i_e_mem2reg),
        .i_m_mem2reg     (i_m_mem2reg),
        .i_e_branch_taken(i_e_branch_taken),
        .o_fwd_sel_a     (o_fwd_sel_a),
        .o_fwd_sel_b     (o_fwd_sel_b),
        .o_stall         (o_stall),
        .o_flush         (o_flush),
        .o_md_busy       (o_md_busy),
        .o_md_done       (o_md_done),
        .o_md_count      (o_md_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             st;
        logic             fl;
        logic             bz;
        logic             dn;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Shadow stimulus: set by the script, applied just after the next rising edge.
    logic       n_clrn, n_use_rs, n_use_rt, n_start, n_op, n_read;
    logic       n_e_wreg, n_m_wreg, n_e_m2r, n_m_m2r, n_br;
    logic [4:0] n_rs, n_rt, n_e_rd, n_m_rd;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clr();
        n_clrn = 1'b1; n_use_rs = 1'b0; n_use_rt = 1'b0;
        n_start = 1'b0; n_op = 1'b0; n_read = 1'b0;
        n_e_wreg = 1'b0; n_m_wreg = 1'b0; n_e_m2r = 1'b0; n_m_m2r = 1'b0; n_br = 1'b0;
        n_rs = 5'd0; n_rt = 5'd0; n_e_rd = 5'd0; n_m_rd = 5'd0;
    endtask

    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic st, input logic fl, input logic bz, input logic dn, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        i_clrn = n_clrn; i_d_use_rs = n_use_rs; i_d_use_rt = n_use_rt;
        i_d_md_start = n_start; i_d_md_op = n_op; i_d_md_read = n_read;
        i_e_wreg = n_e_wreg; i_m_wreg = n_m_wreg; i_e_mem2reg = n_e_m2r; i_m_mem2reg = n_m_m2r;
        i_e_branch_taken = n_br;
        i_d_rs = n_rs; i_d_rt = n_rt; i_e_rd = n_e_rd; i_m_rd = n_m_rd;
        e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.bz = bz; e.dn = dn;
        e.cnt = CNT_W'(cnt);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Scoreboard consumer: compares the cycle's settled outputs.
    exp_t  mon_e;
    string mon_t;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            check_val({mon_t, ".fwd_a"}, 32'(o_fwd_sel_a), 32'(mon_e.fa));
            check_val({mon_t, ".fwd_b"}, 32'(o_fwd_sel_b), 32'(mon_e.fb));
            check_val({mon_t, ".stall"}, 32'(o_stall),     32'(mon_e.st));
            check_val({mon_t, ".flush"}, 32'(o_flush),     32'(mon_e.fl));
            check_val({mon_t, ".busy"},  32'(o_md_busy),   32'(mon_e.bz));
            check_val({mon_t, ".done"},  32'(o_md_done),   32'(mon_e.dn));
            check_val({mon_t, ".count"}, 32'(o_md_count),  32'(mon_e.cnt));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_clrn = 1'b0; i_d_use_rs = 1'b0; i_d_use_rt = 1'b0;
        i_d_md_start = 1'b0; i_d_md_op = 1'b0; i_d_md_read = 1'b0;
        i_e_wreg = 1'b0; i_m_wreg = 1'b0; i_e_mem2reg = 1'b0; i_m_mem2reg = 1'b0;
        i_e_branch_taken = 1'b0;
        i_d_rs = 5'd0; i_d_rt = 5'd0; i_e_rd = 5'd0; i_m_rd = 5'd0;

        // Reset with active-looking inputs: every output must be held at 0.
        clr(); n_clrn = 1'b0; n_br = 1'b1; n_e_rd = 5'd5; n_e_wreg = 1'b1;
        n_rs = 5'd5; n_use_rs = 1'b1; n_start = 1'b1;
        step("rst0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("rst1", 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Forwarding priority.
        clr(); n_e_rd = 5'd5; n_e_wreg = 1'b1; n_m_rd = 5'd5; n_m_wreg = 1'b1;
        n_rs = 5'd5; n_use_rs = 1'b1;
        step("fwd_e", 2'b01, 2'b00, 0, 0, 0, 0, 0);
        n_e_wreg = 1'b0;
        step("fwd_m", 2'b10, 2'b00, 0, 0, 0, 0, 0);
        n_rt = 5'd5; n_use_rt = 1'b1; n_m_m2r = 1'b1;
        step("fwd_ml", 2'b11, 2'b11, 0, 0, 0, 0, 0);

        // Load-use, then the load moves to MEM.
        clr(); n_e_rd = 5'd8; n_e_wreg = 1'b1; n_e_m2r = 1'b1; n_rt = 5'd8; n_use_rt = 1'b1;
        step("lu", 2'b00, 2'b00, 1, 0, 0, 0, 0);
        clr(); n_m_rd = 5'd8; n_m_wreg = 1'b1; n_m_m2r = 1'b1; n_rt = 5'd8; n_use_rt = 1'b1;
        step("lu_m", 2'b00, 2'b11, 0, 0, 0, 0, 0);

        // r0 never forwards or stalls; unused operands never match.
        clr(); n_e_rd = 5'd0; n_e_wreg = 1'b1; n_e_m2r = 1'b1; n_rs = 5'd0; n_use_rs = 1'b1;
        n_m_wreg = 1'b1;
        step("r0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        clr(); n_e_rd = 5'd3; n_e_wreg = 1'b1; n_e_m2r = 1'b1; n_rs = 5'd3; n_rt = 5'd3;
        step("nouse", 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Flush overrides a load-use stall.
        clr(); n_e_rd = 5'd9; n_e_wreg = 1'b1; n_e_m2r = 1'b1; n_rs = 5'd9; n_use_rs = 1'b1; n_br = 1'b1;
        step("lu_br", 2'b00, 2'b00, 0, 1, 0, 0, 0);

        // Multiply with an mfhi held from cycle 2.
        clr(); n_start = 1'b1;
        step("mul0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        clr();
        step("mul1", 2'b00, 2'b00, 0, 0, 1, 0, MUL_CYCLES - 1);
        n_read = 1'b1;
        step("mul2", 2'b00, 2'b00, 1, 0, 1, 0, 2);
        step("mul3", 2'b00, 2'b00, 1, 0, 1, 0, 1);
        step("mul4", 2'b00, 2'b00, 1, 0, 1, 0, 0);
        step("mul5", 2'b00, 2'b00, 0, 0, 0, 1, 0);
        clr();
        step("mul6", 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Start squashed by a taken branch.
        clr(); n_start = 1'b1; n_br = 1'b1;
        step("br0", 2'b00, 2'b00, 0, 1, 0, 0, 0);
        clr();
        step("br1", 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Start while busy is held; start in DONE runs back-to-back.
        clr(); n_start = 1'b1;
        step("bb0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        clr();
        step("bb1", 2'b00, 2'b00, 0, 0, 1, 0, 3);
        n_start = 1'b1;
        step("bb2", 2'b00, 2'b00, 1, 0, 1, 0, 2);
        step("bb3", 2'b00, 2'b00, 1, 0, 1, 0, 1);
        step("bb4", 2'b00, 2'b00, 1, 0, 1, 0, 0);
        step("bb5", 2'b00, 2'b00, 0, 0, 0, 1, 0);
        clr();
        step("bb6", 2'b00, 2'b00, 0, 0, 1, 0, 3);
        // Load-use and MDU busy together: start waits until both clear.
        n_e_rd = 5'd4; n_e_wreg = 1'b1; n_e_m2r = 1'b1; n_rs = 5'd4; n_use_rs = 1'b1; n_start = 1'b1;
        step("bb7", 2'b00, 2'b00, 1, 0, 1, 0, 2);
        step("bb8", 2'b00, 2'b00, 1, 0, 1, 0, 1);
        step("bb9", 2'b00, 2'b00, 1, 0, 1, 0, 0);
        step("bb10", 2'b00, 2'b00, 1, 0, 0, 1, 0);
        step("bb11", 2'b00, 2'b00, 1, 0, 0, 0, 0);
        clr();
        step("bb12", 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Reset aborts a running multiply.
        clr(); n_start = 1'b1;
        step("ra0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        clr();
        step("ra1", 2'b00, 2'b00, 0, 0, 1, 0, 3);
        n_clrn = 1'b0; n_start = 1'b1;
        step("ra2", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        clr();
        step("ra3", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("ra4", 2'b00, 2'b00, 0, 0, 0, 0, 0);

`ifdef MDU_DIV_EN
        // Divide aborted by reset when the count reaches 17.
        clr(); n_start = 1'b1; n_op = 1'b1;
        step("div0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        clr();
        for (int k = 1; k <= 14; k++) begin
            step($sformatf("div%0d", k), 2'b00, 2'b00, 0, 0, 1, 0, DIV_CYCLES - k);
        end
        n_clrn = 1'b0;
        step("div_rst", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        clr();
        step("div_post0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step("div_post1", 2'b00, 2'b00, 0, 0, 0, 0, 0);
`else
        // No divider: done the very next cycle, never busy.
        clr(); n_start = 1'b1; n_op = 1'b1;
        step("div0", 2'b00, 2'b00, 0, 0, 0, 0, 0);
        clr();
        step("div1", 2'b00, 2'b00, 0, 0, 0, 1, 0);
        step("div2", 2'b00, 2'b00, 0, 0, 0, 0, 0);
`endif

        repeat (3) @(negedge clk);
        check_val("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
